// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store requesters.
// Optional define MEM_ARB_ALIGN_CHECK_EN adds alignment/mask checks with error responses.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req_valid,
    input  logic [63:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [31:0] i_resp_data,
`ifdef MEM_ARB_ALIGN_CHECK_EN
    output logic        i_resp_err,
    output logic        d_resp_err,
`endif
    input  logic        d_req_valid,
    input  logic [1:0]  d_req_op,
    input  logic [7:0]  d_req_mask,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_data,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [63:0] d_resp_data,
    output logic        mem_enable,
    output logic [1:0]  mem_op,
    output logic [7:0]  mem_mask,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;   // 1: data granted last
    logic              own_d_q, own_d_d;         // 1: data requester owns the transaction
    logic              is_load_q, is_load_d;
    logic              sel_hi_q, sel_hi_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_enable_q, mem_enable_d;
    logic [1:0]        mem_op_q, mem_op_d;
    logic [7:0]        mem_mask_q, mem_mask_d;
    logic [63:0]       mem_addr_q, mem_addr_d;
    logic [63:0]       mem_data_q, mem_data_d;
    logic              i_resp_valid_q, i_resp_valid_d;
    logic [31:0]       i_resp_data_q, i_resp_data_d;
    logic              d_resp_valid_q, d_resp_valid_d;
    logic [63:0]       d_resp_data_q, d_resp_data_d;
    logic              i_bad, d_bad, d_noop, idle;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic i_resp_err_q, i_resp_err_d;
    logic d_resp_err_q, d_resp_err_d;

    function automatic logic mask_legal(input logic [7:0] m);
        logic ok;
        ok = (m == 8'h00) || (m == 8'hFF);
        for (int k = 0; k < 8; k++) if (m == (8'h01 << k)) ok = 1'b1;
        for (int k = 0; k < 4; k++) if (m == (8'h03 << (2 * k))) ok = 1'b1;
        for (int k = 0; k < 2; k++) if (m == (8'h0F << (4 * k))) ok = 1'b1;
        return ok;
    endfunction

    assign i_bad      = |i_req_addr[1:0];
    assign d_bad      = !d_noop && !mask_legal(d_req_mask);
    assign i_resp_err = i_resp_err_q;
    assign d_resp_err = d_resp_err_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_req_addr[1:0];
    assign i_bad = 1'b0;
    assign d_bad = 1'b0;
`endif

    assign idle   = (state_q == StIdle);
    assign d_noop = (d_req_op == 2'b00) || (d_req_op == 2'b11);

    // Ready is gated by the requester's own valid so at most one is ever high.
    assign i_req_ready = idle && i_req_valid && (!d_req_valid || last_gnt_q);
    assign d_req_ready = idle && d_req_valid && (!i_req_valid || !last_gnt_q);

    always_comb begin
        state_d        = state_q;
        last_gnt_d     = last_gnt_q;
        own_d_d        = own_d_q;
        is_load_d      = is_load_q;
        sel_hi_d       = sel_hi_q;
        cnt_d          = cnt_q;
        mem_enable_d   = 1'b0;
        mem_op_d       = mem_op_q;
        mem_mask_d     = mem_mask_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        i_resp_valid_d = 1'b0;
        i_resp_data_d  = i_resp_data_q;
        d_resp_valid_d = 1'b0;
        d_resp_data_d  = d_resp_data_q;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        i_resp_err_d   = 1'b0;
        d_resp_err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_req_ready) begin
                    last_gnt_d = 1'b0;
                    own_d_d    = 1'b0;
                    sel_hi_d   = i_req_addr[2];
                    is_load_d  = 1'b1;
                    if (i_bad) begin
                        state_d        = StResp;
                        i_resp_valid_d = 1'b1;
                        i_resp_data_d  = '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                        i_resp_err_d   = 1'b1;
`endif
                    end else begin
                        state_d      = StIssue;
                        mem_enable_d = 1'b1;
                        mem_op_d     = 2'b01;
                        mem_mask_d   = 8'hFF;
                        mem_addr_d   = {i_req_addr[63:3], 3'b000};
                        mem_data_d   = '0;
                    end
                end else if (d_req_ready) begin
                    last_gnt_d = 1'b1;
                    own_d_d    = 1'b1;
                    is_load_d  = (d_req_op == 2'b01);
                    if (d_noop || d_bad) begin
                        state_d        = StResp;
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
                        d_resp_err_d   = d_bad;
`endif
                    end else begin
                        state_d      = StIssue;
                        mem_enable_d = 1'b1;
                        mem_op_d     = d_req_op;
                        mem_mask_d   = d_req_mask;
                        mem_addr_d   = d_req_addr;
                        mem_data_d   = d_req_data;
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
                cnt_d   = CntW'(MEM_LAT - 1);
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    if (own_d_q) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = is_load_q ? mem_rdata : 64'd0;
                    end else begin
                        i_resp_valid_d = 1'b1;
                        i_resp_data_d  = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= StIdle;
            last_gnt_q     <= 1'b1;
            own_d_q        <= 1'b0;
            is_load_q      <= 1'b0;
            sel_hi_q       <= 1'b0;
            cnt_q          <= '0;
            mem_enable_q   <= 1'b0;
            mem_op_q       <= '0;
            mem_mask_q     <= '0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            i_resp_valid_q <= 1'b0;
            i_resp_data_q  <= '0;
            d_resp_valid_q <= 1'b0;
            d_resp_data_q  <= '0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            i_resp_err_q   <= 1'b0;
            d_resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            last_gnt_q     <= last_gnt_d;
            own_d_q        <= own_d_d;
            is_load_q      <= is_load_d;
            sel_hi_q       <= sel_hi_d;
            cnt_q          <= cnt_d;
            mem_enable_q   <= mem_enable_d;
            mem_op_q       <= mem_op_d;
            mem_mask_q     <= mem_mask_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            i_resp_valid_q <= i_resp_valid_d;
            i_resp_data_q  <= i_resp_data_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_resp_data_q  <= d_resp_data_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
            i_resp_err_q   <= i_resp_err_d;
            d_resp_err_q   <= d_resp_err_d;
`endif
        end
    end

    assign mem_enable   = mem_enable_q;
    assign mem_op       = mem_op_q;
    assign mem_mask     = mem_mask_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign i_resp_valid = i_resp_valid_q;
    assign i_resp_data  = i_resp_data_q;
    assign d_resp_valid = d_resp_valid_q;
    assign d_resp_data  = d_resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a one-cycle-latency RAM model.
// Honours MEM_ARB_ALIGN_CHECK_EN when defined.
module tb_mem_port_arbiter;
    localparam int unsigned MemLat = 1;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [63:0] i_req_addr;
    logic [31:0] i_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [1:0]  d_req_op;
    logic [7:0]  d_req_mask;
    logic [63:0] d_req_addr, d_req_data, d_resp_data;
    logic        mem_enable;
    logic [1:0]  mem_op;
    logic [7:0]  mem_mask;
    logic [63:0] mem_addr, mem_data, mem_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        i_resp_err, d_resp_err;
`endif

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MEM_LAT(MemLat)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .i_resp_err(i_resp_err), .d_resp_err(d_resp_err),
`endif
        .d_req_valid(d_req_valid), .d_req_op(d_req_op), .d_req_mask(d_req_mask),
        .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_enable(mem_enable), .mem_op(mem_op), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdata(mem_rdata)
    );

    // RAM model: data for the address strobed last cycle.
    logic [63:0] ram_addr_q = '0;
    always @(posedge CLK) if (mem_enable) ram_addr_q <= mem_addr;
    function automatic logic [63:0] ram_word(input logic [63:0] a);
        if (a == 64'h1000) return 64'hDEADBEEF_12345678;
        return {a[31:0] ^ 32'hA5A5A5A5, a[31:0]};
    endfunction
    assign mem_rdata = ram_word(ram_addr_q);

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        is_d;
        logic [1:0]  op;
        logic [7:0]  mask;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        e_en;
        logic [1:0]  e_op;
        logic [7:0]  e_mask;
        logic [63:0] e_addr;
        logic [63:0] e_resp;
        int          e_cyc;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];
    int   nv;

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int          en_cnt, resp_cyc, wrong;
        logic [63:0] g_resp, g_addr, g_data;
        logic [1:0]  g_op;
        logic [7:0]  g_mask;
        logic        g_err;
        en_cnt = 0; resp_cyc = -1; wrong = 0; g_resp = 'x; g_err = 1'b0;
        g_addr = 'x; g_data = 'x; g_op = 'x; g_mask = 'x;
        @(negedge CLK);
        if (v.is_d) begin
            d_req_valid = 1'b1; d_req_op = v.op; d_req_mask = v.mask;
            d_req_addr = v.addr; d_req_data = v.wdata;
        end else begin
            i_req_valid = 1'b1; i_req_addr = v.addr;
        end
        #1;
        chk({v.name, " ready"}, {63'd0, v.is_d ? d_req_ready : i_req_ready}, 64'd1);
        @(negedge CLK);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_enable) begin
                en_cnt++;
                g_op = mem_op; g_mask = mem_mask; g_addr = mem_addr; g_data = mem_data;
            end
            if (v.is_d ? d_resp_valid : i_resp_valid) begin
                if (resp_cyc < 0) resp_cyc = c;
                g_resp = v.is_d ? d_resp_data : {32'd0, i_resp_data};
`ifdef MEM_ARB_ALIGN_CHECK_EN
                g_err = v.is_d ? d_resp_err : i_resp_err;
`endif
            end
            if (v.is_d ? i_resp_valid : d_resp_valid) wrong++;
            @(negedge CLK);
        end
        chk({v.name, " enables"}, 64'(en_cnt), v.e_en ? 64'd1 : 64'd0);
        if (v.e_en) begin
            chk({v.name, " op"}, {62'd0, g_op}, {62'd0, v.e_op});
            chk({v.name, " mask"}, {56'd0, g_mask}, {56'd0, v.e_mask});
            chk({v.name, " addr"}, g_addr, v.e_addr);
            if (v.is_d) chk({v.name, " wdata"}, g_data, v.wdata);
        end
        chk({v.name, " resp cycle"}, 64'(resp_cyc), 64'(v.e_cyc));
        chk({v.name, " resp data"}, g_resp, v.e_resp);
        chk({v.name, " other resp"}, 64'(wrong), 64'd0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        chk({v.name, " err"}, {63'd0, g_err}, {63'd0, v.e_err});
`endif
    endtask

    // Both requesters held valid for n accepts: fetch 0x0 and load 0x80.
    task automatic run_both(input int n, input string tag);
        int          acc, both, bad_gap, bad_op, en_cnt, last_acc;
        logic [7:0]  order, exp_order;
        logic [63:0] last_d;
        acc = 0; both = 0; bad_gap = 0; bad_op = 0; en_cnt = 0; last_acc = 0;
        order = '0; exp_order = '0; last_d = 'x;
        do_reset();
        i_req_valid = 1'b1; i_req_addr = 64'h0;
        d_req_valid = 1'b1; d_req_op = 2'b01; d_req_mask = 8'hFF;
        d_req_addr = 64'h80; d_req_data = '0;
        for (int cyc = 0; cyc < n * 4 + 6; cyc++) begin
            if (acc >= n) begin
                i_req_valid = 1'b0;
                d_req_valid = 1'b0;
            end
            #1;
            if (i_req_ready && d_req_ready) both++;
            if (acc < n && (i_req_ready || d_req_ready)) begin
                order[acc] = d_req_ready;
                if (acc > 0 && cyc - last_acc != 3 + int'(MemLat)) bad_gap++;
                last_acc = cyc;
                acc++;
            end
            if (mem_enable) begin
                en_cnt++;
                if (mem_op != 2'b01) bad_op++;
            end
            if (d_resp_valid) last_d = d_resp_data;
            @(negedge CLK);
        end
        for (int k = 0; k < n; k++) exp_order[k] = k[0];
        chk({tag, " accepts"}, 64'(acc), 64'(n));
        chk({tag, " both ready"}, 64'(both), 64'd0);
        chk({tag, " grant order"}, {56'd0, order}, {56'd0, exp_order});
        chk({tag, " accept gap"}, 64'(bad_gap), 64'd0);
        chk({tag, " enables"}, 64'(en_cnt), 64'(n));
        chk({tag, " enable op"}, 64'(bad_op), 64'd0);
        chk({tag, " load data"}, last_d, 64'hA5A5A525_00000080);
    endtask

    initial begin
        int stray;
        vecs[0] = '{"fetch_1004", 0, 2'b01, 8'hFF, 64'h1004, 64'd0,
                    1, 2'b01, 8'hFF, 64'h1000, 64'hDEADBEEF, 3, 0};
        vecs[1] = '{"fetch_1000", 0, 2'b01, 8'hFF, 64'h1000, 64'd0,
                    1, 2'b01, 8'hFF, 64'h1000, 64'h12345678, 3, 0};
        vecs[2] = '{"fetch_2004", 0, 2'b01, 8'hFF, 64'h2004, 64'd0,
                    1, 2'b01, 8'hFF, 64'h2000, 64'hA5A585A5, 3, 0};
        vecs[3] = '{"load_80", 1, 2'b01, 8'hFF, 64'h80, 64'd0,
                    1, 2'b01, 8'hFF, 64'h80, 64'hA5A5A525_00000080, 3, 0};
        vecs[4] = '{"store_80", 1, 2'b10, 8'h0F, 64'h80, 64'h1122334455667788,
                    1, 2'b10, 8'h0F, 64'h80, 64'd0, 3, 0};
        vecs[5] = '{"noop_00", 1, 2'b00, 8'hFF, 64'h40, 64'h55,
                    0, 2'b00, 8'h00, 64'h0, 64'd0, 1, 0};
        vecs[6] = '{"noop_11", 1, 2'b11, 8'h0F, 64'h48, 64'h66,
                    0, 2'b00, 8'h00, 64'h0, 64'd0, 1, 0};
        nv = 7;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        vecs[nv++] = '{"fetch_misaligned", 0, 2'b01, 8'hFF, 64'h1002, 64'd0,
                       0, 2'b00, 8'h00, 64'h0, 64'd0, 1, 1};
        vecs[nv++] = '{"load_mask06", 1, 2'b01, 8'h06, 64'h80, 64'd0,
                       0, 2'b00, 8'h00, 64'h0, 64'd0, 1, 1};
        vecs[nv++] = '{"store_mask30", 1, 2'b10, 8'h30, 64'h88, 64'h99,
                       1, 2'b10, 8'h30, 64'h88, 64'd0, 3, 0};
`else
        vecs[nv++] = '{"load_mask06", 1, 2'b01, 8'h06, 64'h88, 64'd0,
                       1, 2'b01, 8'h06, 64'h88, 64'hA5A5A52D_00000088, 3, 0};
`endif

        RESET = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0;
        d_req_valid = 1'b0; d_req_op = '0; d_req_mask = '0; d_req_addr = '0; d_req_data = '0;
        #1;
        chk("reset mem_enable", {63'd0, mem_enable}, 64'd0);
        chk("reset i_resp_valid", {63'd0, i_resp_valid}, 64'd0);
        chk("reset d_resp_valid", {63'd0, d_resp_valid}, 64'd0);
        chk("reset mem_addr", mem_addr, 64'd0);
        chk("reset d_resp_data", d_resp_data, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < nv; i++) run_vec(vecs[i]);

        run_both(2, "conflict");
        run_both(6, "alternate");

        // Reset while waiting on the RAM: transaction is dropped.
        do_reset();
        @(negedge CLK);
        i_req_valid = 1'b1; i_req_addr = 64'h1004;
        @(posedge CLK);
        @(negedge CLK);
        i_req_valid = 1'b0;
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("wait reset mem_enable", {63'd0, mem_enable}, 64'd0);
        chk("wait reset i_resp_valid", {63'd0, i_resp_valid}, 64'd0);
        chk("wait reset d_resp_valid", {63'd0, d_resp_valid}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (i_resp_valid || d_resp_valid || mem_enable) stray++;
        end
        chk("wait reset dropped", 64'(stray), 64'd0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
